alu_issue_stage: RTL

- Upstream neighbour of the ALU: accepts one 32-bit MIPS R-type instruction at a time over a valid/ready handshake.
- Decodes funct/shamt into the ALU's 4-bit control and 3-bit bonus control.
- Reads operands from an internal 32x32 register file, holds them stable for the ALU, then writes the ALU result back to rd.
- Sequential 4-state FSM; one instruction in flight; no pipelining.

---
 rtl/alu_defs_pkg.sv | 82 ++++++++
 rtl/alu_issue_stage_regfile.sv | 43 ++++
 rtl/alu_issue_stage.sv | 107 ++++++++++
 3 files changed

// File: rtl/alu_defs_pkg.sv
// Shared encodings for the ALU issue stage: ALU control codes, compare codes,
// funct values, FSM states, instruction layout and the R-type decoder.
package alu_defs;

  localparam int unsigned NREG = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned CW   = 4;
  localparam int unsigned BW   = 3;

  localparam logic [CW-1:0] ALU_AND  = 4'b0000;
  localparam logic [CW-1:0] ALU_OR   = 4'b0001;
  localparam logic [CW-1:0] ALU_ADD  = 4'b0010;
  localparam logic [CW-1:0] ALU_SUB  = 4'b0110;
  localparam logic [CW-1:0] ALU_NOR  = 4'b1100;
  localparam logic [CW-1:0] ALU_NAND = 4'b1101;
  localparam logic [CW-1:0] ALU_CMP  = 4'b0111;

  // Compare sub-codes carried in shamt[2:0]; 100 and 101 have no meaning.
  localparam logic [BW-1:0] CMP_SLT  = 3'b000;
  localparam logic [BW-1:0] CMP_SLTU = 3'b001;
  localparam logic [BW-1:0] CMP_SGT  = 3'b010;
  localparam logic [BW-1:0] CMP_SGTU = 3'b011;
  localparam logic [BW-1:0] CMP_RSV0 = 3'b100;
  localparam logic [BW-1:0] CMP_RSV1 = 3'b101;
  localparam logic [BW-1:0] CMP_SLE  = 3'b110;
  localparam logic [BW-1:0] CMP_SGE  = 3'b111;

  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_NAND = 6'h26;
  localparam logic [5:0] FUNCT_CMP  = 6'h2A;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DECODE = 2'b01,
    ST_EXEC   = 2'b10,
    ST_WB     = 2'b11
  } state_t;

  typedef struct packed {
    logic [5:0]    op;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic [AW-1:0] shamt;
    logic [5:0]    funct;
  } rtype_t;

  typedef struct packed {
    logic          legal;
    logic [CW-1:0] ctrl;
    logic [BW-1:0] bonus;
  } dec_t;

  function automatic dec_t decode(input rtype_t i);
    dec_t d;
    d.legal = 1'b1;
    d.ctrl  = ALU_AND;
    d.bonus = '0;
    case (i.funct)
      FUNCT_AND:  d.ctrl = ALU_AND;
      FUNCT_OR:   d.ctrl = ALU_OR;
      FUNCT_ADD:  d.ctrl = ALU_ADD;
      FUNCT_SUB:  d.ctrl = ALU_SUB;
      FUNCT_NOR:  d.ctrl = ALU_NOR;
      FUNCT_NAND: d.ctrl = ALU_NAND;
      FUNCT_CMP: begin
        d.ctrl  = ALU_CMP;
        d.bonus = i.shamt[BW-1:0];
        if (i.shamt[BW-1:0] == CMP_RSV0 || i.shamt[BW-1:0] == CMP_RSV1) d.legal = 1'b0;
      end
      default:    d.legal = 1'b0;
    endcase
    if (i.op != 6'd0) d.legal = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_stage_regfile.sv
// 32-entry register file with r0 fixed at zero, a pair of capture-on-enable
// operand read ports, one write port and a combinational debug read port.
module issue_regfile
  import alu_defs::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_en,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] rf [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
    end else if (we && waddr != '0) begin
      rf[waddr] <= wdata;
    end
  end

  // Operand latches double as the ALU source registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rs_data <= '0;
      rt_data <= '0;
    end else if (rd_en) begin
      rs_data <= rf[rs_addr];
      rt_data <= rf[rt_addr];
    end
  end

  assign dbg_data = (dbg_addr == '0) ? '0 : rf[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the ALU: accepts one R-type instruction, decodes it,
// presents operands for a full cycle, then writes the ALU result back.
module alu_issue_stage
  import alu_defs::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inst_valid,
  output logic          inst_ready,
  input  logic [31:0]   inst,
  output logic [DW-1:0] alu_src1,
  output logic [DW-1:0] alu_src2,
  output logic [CW-1:0] alu_ctrl,
  output logic [BW-1:0] alu_bonus,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_zero,
  input  logic          alu_cout,
  input  logic          alu_overflow,
  output logic          done,
  output logic          illegal,
  output logic [2:0]    flags,
  input  logic          init_we,
  input  logic [AW-1:0] init_addr,
  input  logic [DW-1:0] init_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  state_t        state, state_nx;
  rtype_t        inst_q;
  dec_t          dec;
  logic          rd_en;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Write port is shared between preload (IDLE) and writeback (WB).
  always_comb begin
    state_nx = state;
    rd_en    = 1'b0;
    we       = 1'b0;
    waddr    = init_addr;
    wdata    = init_data;
    dec      = decode(inst_q);
    case (state)
      ST_IDLE: begin
        we = init_we && (init_addr != '0);
        if (inst_valid) state_nx = ST_DECODE;
      end
      ST_DECODE: begin
        rd_en    = dec.legal;
        state_nx = dec.legal ? ST_EXEC : ST_IDLE;
      end
      ST_EXEC: state_nx = ST_WB;
      ST_WB: begin
        we       = (inst_q.rd != '0);
        waddr    = inst_q.rd;
        wdata    = alu_result;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_q    <= '0;
      alu_ctrl  <= '0;
      alu_bonus <= '0;
      flags     <= '0;
      done      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      done    <= (state == ST_WB);
      illegal <= (state == ST_DECODE) && !dec.legal;
      if (state == ST_IDLE && inst_valid) inst_q <= rtype_t'(inst);
      if (state == ST_DECODE && dec.legal) begin
        alu_ctrl  <= dec.ctrl;
        alu_bonus <= dec.bonus;
      end
      if (state == ST_WB) flags <= {alu_zero, alu_cout, alu_overflow};
    end
  end

  assign inst_ready = (state == ST_IDLE);

  issue_regfile u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (rd_en),
    .rs_addr  (inst_q.rs),
    .rt_addr  (inst_q.rt),
    .rs_data  (alu_src1),
    .rt_data  (alu_src2),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

endmodule
